// File: rtl/word_assembler.sv
// Packs BYTES consecutive UART byte slots into one word (LSB first), with error substitution and inter-byte timeout.
// Optional error/timeout counter output enabled by defining WORD_ASSEMBLER_ERR_CNT_EN.
module word_assembler #(
    parameter int unsigned BYTES    = 2,
    parameter logic [7:0]  ERR_BYTE = 8'hCC,
    parameter int unsigned TIMEOUT  = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         data_in,
    input  logic               valid,
    input  logic               PERROR,
    input  logic               FERROR,
    output logic [8*BYTES-1:0] out,
    output logic               out_valid,
    output logic               timeout_flag
`ifdef WORD_ASSEMBLER_ERR_CNT_EN
    ,
    output logic [15:0]        err_count
`endif
);

    localparam int unsigned SH = (BYTES > 1) ? BYTES - 1 : 1;
    localparam int unsigned CW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned IW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(BYTES - 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);
    localparam logic [8*BYTES-1:0] ERR_WORD = {BYTES{ERR_BYTE}};

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [8*SH-1:0]     shadow_q, shadow_d;
    logic                err_q, err_d;
    logic [IW-1:0]       idle_q, idle_d;
    logic [8*BYTES-1:0]  out_d;
    logic                out_valid_d;
    logic                timeout_d;
    logic                slot_event;
    logic                slot_err;
    logic                bump_err;
    logic [8*BYTES-1:0]  word_ok;

    assign slot_event = valid | PERROR | FERROR;
    assign slot_err   = PERROR | FERROR;

    always_comb begin
        word_ok = '0;
        for (int unsigned i = 0; i < BYTES - 1; i++) begin
            word_ok[8*i +: 8] = shadow_q[8*i +: 8];
        end
        word_ok[8*BYTES-1 -: 8] = data_in;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        err_d       = err_q;
        idle_d      = idle_q;
        out_d       = out;
        out_valid_d = 1'b0;
        timeout_d   = 1'b0;
        bump_err    = 1'b0;

        // An event in the timeout cycle takes priority over discarding the partial word
        if (slot_event) begin
            idle_d = '0;
            if (cnt_q == LAST) begin
                out_valid_d = 1'b1;
                cnt_d       = '0;
                err_d       = 1'b0;
                state_d     = IDLE;
                if (!err_q && !slot_err) begin
                    out_d = word_ok;
                end else begin
                    out_d    = ERR_WORD;
                    bump_err = 1'b1;
                end
            end else begin
                if (slot_err) begin
                    err_d = 1'b1;
                end else begin
                    for (int unsigned i = 0; i < SH; i++) begin
                        if (cnt_q == CW'(i)) shadow_d[8*i +: 8] = data_in;
                    end
                end
                cnt_d   = cnt_q + 1'b1;
                state_d = COLLECT;
            end
        end else if (state_q == COLLECT) begin
            if (idle_q == IDLE_MAX) begin
                cnt_d     = '0;
                err_d     = 1'b0;
                idle_d    = '0;
                timeout_d = 1'b1;
                bump_err  = 1'b1;
                state_d   = IDLE;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end else begin
            idle_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shadow_q     <= '0;
            err_q        <= 1'b0;
            idle_q       <= '0;
            out          <= '0;
            out_valid    <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            err_q        <= err_d;
            idle_q       <= idle_d;
            out          <= out_d;
            out_valid    <= out_valid_d;
            timeout_flag <= timeout_d;
        end
    end

`ifdef WORD_ASSEMBLER_ERR_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count <= '0;
        end else if (bump_err && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end
`else
    logic unused_bump;
    assign unused_bump = bump_err;
`endif

endmodule

// File: tb/tb_word_assembler.sv
// Scoreboard bench for word_assembler: a 2-byte instance (short timeout) and a 4-byte instance.
module tb_word_assembler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  din_a = '0, din_b = '0;
    logic        val_a = 1'b0, pe_a = 1'b0, fe_a = 1'b0;
    logic        val_b = 1'b0, pe_b = 1'b0, fe_b = 1'b0;
    logic [15:0] out_a;
    logic [31:0] out_b;
    logic        ov_a, ov_b, tf_a, tf_b;
`ifdef WORD_ASSEMBLER_ERR_CNT_EN
    logic [15:0] ec_a, ec_b;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_cyc = 0;

    typedef struct {
        bit          tmo;
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    word_assembler #(.BYTES(2), .ERR_BYTE(8'hCC), .TIMEOUT(8)) dut_a (
        .clk(clk), .reset(reset), .data_in(din_a), .valid(val_a),
        .PERROR(pe_a), .FERROR(fe_a), .out(out_a), .out_valid(ov_a),
        .timeout_flag(tf_a)
`ifdef WORD_ASSEMBLER_ERR_CNT_EN
        , .err_count(ec_a)
`endif
    );

    word_assembler #(.BYTES(4), .ERR_BYTE(8'hCC), .TIMEOUT(1000)) dut_b (
        .clk(clk), .reset(reset), .data_in(din_b), .valid(val_b),
        .PERROR(pe_b), .FERROR(fe_b), .out(out_b), .out_valid(ov_b),
        .timeout_flag(tf_b)
`ifdef WORD_ASSEMBLER_ERR_CNT_EN
        , .err_count(ec_b)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // One slot strobe on the chosen instance; last_cyc is the cycle stamp of the sampling edge
    task automatic strobe(input bit which, input logic [7:0] b, input logic v, input logic p, input logic f);
        @(negedge clk);
        if (!which) begin din_a = b; val_a = v; pe_a = p; fe_a = f; end
        else        begin din_b = b; val_b = v; pe_b = p; fe_b = f; end
        @(posedge clk);
        #1;
        din_a = '0; val_a = 1'b0; pe_a = 1'b0; fe_a = 1'b0;
        din_b = '0; val_b = 1'b0; pe_b = 1'b0; fe_b = 1'b0;
        last_cyc = cyc;
    endtask

    task automatic expect_a(input bit tmo, input logic [31:0] v, input int c);
        qa.push_back('{tmo: tmo, val: v, cyc: c});
    endtask

    task automatic expect_b(input bit tmo, input logic [31:0] v, input int c);
        qb.push_back('{tmo: tmo, val: v, cyc: c});
    endtask

    always @(negedge clk) begin
        if (reset && (ov_a || tf_a)) begin
            total++;
            if (qa.size() == 0) begin
                bad++;
                $display("FAIL a_unexpected: out_valid=%b timeout_flag=%b out=%h cyc=%0d expected no pulse", ov_a, tf_a, out_a, cyc);
            end else begin
                exp_t e;
                e = qa.pop_front();
                if (tf_a !== e.tmo || ov_a !== !e.tmo || out_a !== e.val[15:0] || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL a_event: got tmo=%b ov=%b out=%h cyc=%0d expected tmo=%b out=%h cyc=%0d",
                             tf_a, ov_a, out_a, cyc, e.tmo, e.val[15:0], e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset && (ov_b || tf_b)) begin
            total++;
            if (qb.size() == 0) begin
                bad++;
                $display("FAIL b_unexpected: out_valid=%b timeout_flag=%b out=%h cyc=%0d expected no pulse", ov_b, tf_b, out_b, cyc);
            end else begin
                exp_t e;
                e = qb.pop_front();
                if (tf_b !== e.tmo || ov_b !== !e.tmo || out_b !== e.val || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL b_event: got tmo=%b ov=%b out=%h cyc=%0d expected tmo=%b out=%h cyc=%0d",
                             tf_b, ov_b, out_b, cyc, e.tmo, e.val, e.cyc);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        repeat (3) @(negedge clk);
        check("reset_out_a", {16'h0, out_a}, 32'h0);
        check("reset_out_b", out_b, 32'h0);
        check("reset_flags", {28'h0, ov_a, tf_a, ov_b, tf_b}, 32'h0);
`ifdef WORD_ASSEMBLER_ERR_CNT_EN
        check("reset_errcnt", {ec_a, ec_b}, 32'h0);
`endif
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Plain pair, LSB first
        strobe(0, 8'h34, 1, 0, 0);
        strobe(0, 8'h12, 1, 0, 0);
        expect_a(0, 32'h1234, last_cyc);

        // Parity-error slot poisons the word; following word is clean
        strobe(0, 8'h00, 0, 1, 0);
        strobe(0, 8'h55, 1, 0, 0);
        expect_a(0, 32'hCCCC, last_cyc);
        strobe(0, 8'h01, 1, 0, 0);
        strobe(0, 8'h02, 1, 0, 0);
        expect_a(0, 32'h0201, last_cyc);

        // Timeout 8 cycles after a lone strobe; out keeps the previous word
        strobe(0, 8'hAA, 1, 0, 0);
        t0 = last_cyc;
        expect_a(1, 32'h0201, t0 + 8);
        repeat (20) @(posedge clk);
        check("out_after_timeout", {16'h0, out_a}, 32'h0201);
        strobe(0, 8'h11, 1, 0, 0);
        strobe(0, 8'h22, 1, 0, 0);
        expect_a(0, 32'h2211, last_cyc);

        // Second slot lands exactly in the timeout cycle: accepted, no timeout
        strobe(0, 8'hAA, 1, 0, 0);
        repeat (7) @(posedge clk);
        strobe(0, 8'hBB, 1, 0, 0);
        expect_a(0, 32'hBBAA, last_cyc);

        // 4-byte clean word, then valid+FERROR in slot 2
        strobe(1, 8'h11, 1, 0, 0);
        strobe(1, 8'h22, 1, 0, 0);
        strobe(1, 8'h33, 1, 0, 0);
        strobe(1, 8'h44, 1, 0, 0);
        expect_b(0, 32'h44332211, last_cyc);
        strobe(1, 8'h01, 1, 0, 0);
        strobe(1, 8'h99, 1, 0, 1);
        strobe(1, 8'h03, 1, 0, 0);
        strobe(1, 8'h04, 1, 0, 0);
        expect_b(0, 32'hCCCCCCCC, last_cyc);

        repeat (3) @(negedge clk);
        check("hold_out_a", {16'h0, out_a}, 32'hBBAA);
        check("hold_out_b", out_b, 32'hCCCCCCCC);
`ifdef WORD_ASSEMBLER_ERR_CNT_EN
        check("errcnt_a", {16'h0, ec_a}, 32'd2);
        check("errcnt_b", {16'h0, ec_b}, 32'd1);
`endif

        // Reset in the middle of a word
        strobe(0, 8'h77, 1, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("async_reset_out_a", {16'h0, out_a}, 32'h0);
        check("async_reset_out_b", out_b, 32'h0);
        repeat (3) begin
            @(negedge clk);
            check("in_reset_out_valid", {30'h0, ov_a, tf_a}, 32'h0);
        end
        reset = 1'b1;
        strobe(0, 8'h01, 1, 0, 0);
        strobe(0, 8'h02, 1, 0, 0);
        expect_a(0, 32'h0201, last_cyc);

        repeat (4) @(negedge clk);
        check("queue_a_drained", qa.size(), 32'd0);
        check("queue_b_drained", qb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/word_assembler.md
Name: word_assembler

Overview:
- Clocked, parametrised successor to the receiver-to-LED-driver packing register.
- Collects BYTES consecutive byte slots from the UART receiver and presents them as one wide word, least significant byte first.
- Any slot closed by a parity or framing error replaces the whole word with a fixed error pattern.
- An inter-byte timeout discards stale partial words; a one-cycle strobe marks each new word for the LED driver.

Parameters:
- BYTES, 2, bytes per output word (2..8).
- ERR_BYTE, 8'hCC, byte replicated BYTES times to form the error word.
- TIMEOUT, 1000, idle clk cycles allowed between slots of one word before the partial word is discarded (>=2).

Ports:
- clk  input  1  system clock.
- reset  input  1  reset, asynchronous, active-low.
- data_in  input  8  received byte; sampled only when valid=1.
- valid  input  1  one-cycle strobe, byte received correctly.
- PERROR  input  1  one-cycle strobe, parity error on current byte.
- FERROR  input  1  one-cycle strobe, framing error on current byte.
- out  output  8*BYTES  last completed word.
- out_valid  output  1  one-cycle pulse, out just updated.
- timeout_flag  output  1  one-cycle pulse, partial word discarded.

Behaviour:
- All strobes are synchronous to clk. A slot event is any of valid, PERROR or FERROR high in a cycle.
- Same-cycle valid with PERROR/FERROR counts as one error slot; data_in is ignored.
- Internal state:
  - slot counter cnt, 0..BYTES-1;
  - shadow buffer of (BYTES-1) bytes;
  - sticky err flag;
  - idle counter.
- Reset (reset=0, asynchronous): out=0, out_valid=0, timeout_flag=0, cnt=0, err=0, idle=0, shadow=0.
- States:
  - IDLE (cnt==0);
  - COLLECT (0<cnt<BYTES).
- Non-final slot event (cnt<BYTES-1):
  - valid: store data_in in shadow byte cnt;
  - error: set err;
  - then cnt+1, idle cleared.
- Final slot event (cnt==BYTES-1):
  - on that same edge out is written;
  - if err=0 and the event is valid: out = {data_in, shadow[BYTES-2..0]}, byte 0 in out[7:0];
  - otherwise: out = {BYTES{ERR_BYTE}};
  - out_valid=1 for exactly the following cycle;
  - cnt=0, err=0, return to IDLE.
- Latency: out/out_valid are visible one cycle after the final strobe is sampled.
- out holds its value until the next completed word or reset.
- Timeout (COLLECT only):
  - idle increments each cycle with no event;
  - when idle reaches TIMEOUT-1 with no event that cycle: cnt=0, err=0, idle=0, timeout_flag pulses 1 cycle, out unchanged, out_valid stays 0;
  - an event arriving in that same cycle wins: it is accepted normally and no timeout occurs.
- In IDLE, idle is held at 0; no timeout.
- BYTES==1: every event completes a word directly; the shadow buffer is unused.
- Reset mid-word drops the partial word immediately; no out_valid is generated.
- Back-to-back strobes on consecutive cycles are all accepted; no event is ever dropped.

Optional Feature:
- Macro: WORD_ASSEMBLER_ERR_CNT_EN.
- Defined:
  - adds output err_count, 16 bits, counting words emitted as the error pattern plus timeouts;
  - saturates at 16'hFFFF;
  - cleared only by reset;
  - updates on the same edge as out or timeout_flag.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- BYTES=2; valid with 8'h34, then valid with 8'h12 -> out=16'h1234 one cycle after second strobe; out_valid high exactly 1 cycle.
- BYTES=2; PERROR, then valid with 8'h55 -> out=16'hCCCC, out_valid pulse; next clean pair 8'h01,8'h02 -> out=16'h0201 (err cleared).
- BYTES=2, TIMEOUT=8; valid 8'hAA, then 20 idle cycles -> timeout_flag pulse 8 cycles after strobe, out unchanged; then 8'h11,8'h22 -> out=16'h2211.
- BYTES=4; valid+FERROR same cycle in slot 2, other slots valid -> out=32'hCCCCCCCC after slot 4; with WORD_ASSEMBLER_ERR_CNT_EN, err_count=1.
- BYTES=2; valid 8'h77, reset pulsed low mid-word, then 8'h01,8'h02 -> out=0 and no out_valid during reset, then out=16'h0201.
